// File: rtl/system.sv
// rtl/system.sv - Fibonacci compute followed by multiplexed 7-segment hex display of the result
module system #(
  parameter int N_TERMS      = 10,
  parameter int DIGIT_CYCLES = 4,
  parameter int SCAN_ROUNDS  = 1
) (
  input  logic       clk,
  input  logic       resetn,
  output logic       trap,
  output logic [7:0] an_out,
  output logic [7:0] c_out,
  output logic       out_byte_en
);

  typedef enum logic [1:0] {COMPUTE, DISPLAY, DONE} state_t;

  localparam logic [31:0] N_K         = 32'(N_TERMS);
  localparam logic [31:0] HOLD_LAST   = 32'(DIGIT_CYCLES - 1);
  localparam logic [31:0] ROUNDS_LAST = 32'(SCAN_ROUNDS - 1);

  state_t      state, state_n;
  logic [31:0] a, a_n, b, b_n, k, k_n;
  logic [31:0] result, result_n;
  logic [31:0] hold, hold_n, rounds, rounds_n;
  logic [2:0]  d, d_n, nxt;
  logic        trap_n, strobe_n;
  logic [7:0]  an_n, c_n;

  // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one hex nibble, dp off.
  function automatic logic [7:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 8'hC0;  4'h1: seg = 8'hF9;  4'h2: seg = 8'hA4;  4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;  4'h5: seg = 8'h92;  4'h6: seg = 8'h82;  4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;  4'h9: seg = 8'h90;  4'hA: seg = 8'h88;  4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;  4'hD: seg = 8'hA1;  4'hE: seg = 8'h86;  default: seg = 8'h8E;
    endcase
  endfunction

  // Next-state and next-output logic; outputs are computed one cycle ahead so they leave a flop.
  always_comb begin
    state_n  = state;
    a_n      = a;
    b_n      = b;
    k_n      = k;
    result_n = result;
    hold_n   = hold;
    rounds_n = rounds;
    d_n      = d;
    trap_n   = trap;
    an_n     = an_out;
    c_n      = c_out;
    strobe_n = 1'b0;
    nxt      = d + 3'd1;
    case (state)
      COMPUTE: begin
        if (k == N_K) begin
          // The first digit is driven on the same edge that latches the result.
          result_n = a;
          state_n  = DISPLAY;
          d_n      = 3'd0;
          hold_n   = 32'd0;
          rounds_n = 32'd0;
          an_n     = 8'hFE;
          c_n      = seg(a[3:0]);
          strobe_n = 1'b1;
        end else begin
          a_n = b;
          b_n = a + b;
          k_n = k + 32'd1;
        end
      end
      DISPLAY: begin
        if (hold == HOLD_LAST) begin
          hold_n = 32'd0;
          if (d == 3'd7 && rounds == ROUNDS_LAST) begin
            state_n = DONE;
            an_n    = 8'hFF;
            c_n     = 8'hFF;
            trap_n  = 1'b1;
          end else begin
            // nxt wraps 7 -> 0, which restarts the scan for the next round.
            if (d == 3'd7) rounds_n = rounds + 32'd1;
            d_n      = nxt;
            an_n     = ~(8'd1 << nxt);
            c_n      = seg(4'(result >> {nxt, 2'b00}));
            strobe_n = 1'b1;
          end
        end else begin
          hold_n = hold + 32'd1;
        end
      end
      DONE: begin
        an_n   = 8'hFF;
        c_n    = 8'hFF;
        trap_n = 1'b1;
      end
      default: state_n = COMPUTE;
    endcase
  end

  // State and output registers, cleared immediately by resetn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= COMPUTE;
      a           <= 32'd0;
      b           <= 32'd1;
      k           <= 32'd0;
      result      <= 32'd0;
      hold        <= 32'd0;
      rounds      <= 32'd0;
      d           <= 3'd0;
      trap        <= 1'b0;
      an_out      <= 8'hFF;
      c_out       <= 8'hFF;
      out_byte_en <= 1'b0;
    end else begin
      state       <= state_n;
      a           <= a_n;
      b           <= b_n;
      k           <= k_n;
      result      <= result_n;
      hold        <= hold_n;
      rounds      <= rounds_n;
      d           <= d_n;
      trap        <= trap_n;
      an_out      <= an_n;
      c_out       <= c_n;
      out_byte_en <= strobe_n;
    end
  end

endmodule

// File: tb/tb_system.sv
// tb/tb_system.sv - Self-checking bench for system across four parameter sets with a cycle-level reference model
module tb_system;

  localparam int NI = 4;
  localparam int NT [NI] = '{10, 47, 48, 0};
  localparam int DC [NI] = '{4, 4, 4, 1};
  localparam int SR [NI] = '{1, 1, 1, 2};
  localparam int RUN_CYCLES = 140;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] an_w [NI];
  logic [7:0] c_w [NI];
  logic       trap_w [NI];
  logic       stb_w [NI];

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int vectors = 0;
  int miscompares = 0;
  int t = 0;
  int stb_count [NI];

  always #5 clk = ~clk;

  system #(.N_TERMS(NT[0]), .DIGIT_CYCLES(DC[0]), .SCAN_ROUNDS(SR[0])) u0 (
    .clk(clk), .resetn(resetn), .trap(trap_w[0]), .an_out(an_w[0]), .c_out(c_w[0]), .out_byte_en(stb_w[0]));
  system #(.N_TERMS(NT[1]), .DIGIT_CYCLES(DC[1]), .SCAN_ROUNDS(SR[1])) u1 (
    .clk(clk), .resetn(resetn), .trap(trap_w[1]), .an_out(an_w[1]), .c_out(c_w[1]), .out_byte_en(stb_w[1]));
  system #(.N_TERMS(NT[2]), .DIGIT_CYCLES(DC[2]), .SCAN_ROUNDS(SR[2])) u2 (
    .clk(clk), .resetn(resetn), .trap(trap_w[2]), .an_out(an_w[2]), .c_out(c_w[2]), .out_byte_en(stb_w[2]));
  system #(.N_TERMS(NT[3]), .DIGIT_CYCLES(DC[3]), .SCAN_ROUNDS(SR[3])) u3 (
    .clk(clk), .resetn(resetn), .trap(trap_w[3]), .an_out(an_w[3]), .c_out(c_w[3]), .out_byte_en(stb_w[3]));

  function automatic logic [31:0] fib(input int n);
    logic [31:0] x = 32'd0;
    logic [31:0] y = 32'd1;
    logic [31:0] s;
    for (int i = 0; i < n; i++) begin
      s = x + y;
      x = y;
      y = s;
    end
    return x;
  endfunction

  // Expected outputs t rising edges after reset release, from the timeline arithmetic alone.
  task automatic model(input int idx, input int tt, output logic [7:0] an, output logic [7:0] c,
                       output logic s, output logic tr);
    int i;
    int dig;
    logic [31:0] r;
    an = 8'hFF; c = 8'hFF; s = 1'b0; tr = 1'b0;
    if (tt > NT[idx]) begin
      i = tt - (NT[idx] + 1);
      if (i >= 8 * DC[idx] * SR[idx]) begin
        tr = 1'b1;
      end else begin
        dig = (i / DC[idx]) % 8;
        r   = fib(NT[idx]);
        an  = ~(8'd1 << dig);
        c   = seg_tab[(r >> (4 * dig)) & 32'hF];
        s   = ((i % DC[idx]) == 0);
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int tt);
    logic [7:0] an, c;
    logic s, tr;
    for (int i = 0; i < NI; i++) begin
      model(i, tt, an, c, s, tr);
      cmp($sformatf("u%0d t%0d an_out", i, tt), 32'(an_w[i]), 32'(an));
      cmp($sformatf("u%0d t%0d c_out", i, tt), 32'(c_w[i]), 32'(c));
      cmp($sformatf("u%0d t%0d out_byte_en", i, tt), 32'(stb_w[i]), 32'(s));
      cmp($sformatf("u%0d t%0d trap", i, tt), 32'(trap_w[i]), 32'(tr));
      if (stb_w[i] === 1'b1) stb_count[i]++;
    end
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < NI; i++) begin
      cmp($sformatf("u%0d %s an_out", i, tag), 32'(an_w[i]), 32'hFF);
      cmp($sformatf("u%0d %s c_out", i, tag), 32'(c_w[i]), 32'hFF);
      cmp($sformatf("u%0d %s out_byte_en", i, tag), 32'(stb_w[i]), 32'd0);
      cmp($sformatf("u%0d %s trap", i, tag), 32'(trap_w[i]), 32'd0);
    end
  endtask

  // Release reset on a falling edge and check every cycle up to 'upto' edges.
  task automatic release_and_run(input int upto);
    resetn = 1'b1;
    t = 0;
    for (int i = 0; i < NI; i++) stb_count[i] = 0;
    check_all(t);
    while (t < upto) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      check_all(t);
    end
  endtask

  task automatic check_strobe_totals(input string tag);
    for (int i = 0; i < NI; i++)
      cmp($sformatf("u%0d %s strobe_count", i, tag), 32'(stb_count[i]), 32'(8 * SR[i]));
  endtask

  initial begin
    int abort_t;
    // Long reset: outputs must sit at their idle values throughout.
    resetn = 1'b0;
    repeat (100) begin
      @(negedge clk);
      check_reset("in_reset");
    end

    // Full run for all four configurations, including 50+ cycles past trap.
    release_and_run(RUN_CYCLES);
    check_strobe_totals("run1");

    // Short reset, then abort asynchronously while the default unit shows digit 3.
    @(negedge clk);
    resetn = 1'b0;
    repeat ($urandom_range(2, 5)) @(negedge clk);
    abort_t = int'($urandom_range(23, 26));
    release_and_run(abort_t);
    #($urandom_range(1, 3));
    resetn = 1'b0;
    #1;
    check_reset("async_abort");
    repeat ($urandom_range(1, 6)) @(negedge clk);
    check_reset("held_after_abort");

    // The sequence after release must repeat the first run exactly.
    release_and_run(RUN_CYCLES);
    check_strobe_totals("run2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
